// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for one single-port synchronous RAM, with
// an optional per-requester lock and a registered response tag.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_we_0,
  input  logic                  req_we_1,
  input  logic                  req_lock_0,
  input  logic                  req_lock_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  resp_valid_0,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_data_0,
  output logic [DATA_WIDTH-1:0] resp_data_1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [CNT_WIDTH-1:0]  gnt_cnt_0,
  output logic [CNT_WIDTH-1:0]  gnt_cnt_1
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  resp_v0_q, resp_v0_d;
  logic                  resp_v1_q, resp_v1_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic                  grant0_c, grant1_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB;
      prio_q    <= 1'b0;
      resp_v0_q <= 1'b0;
      resp_v1_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      resp_v0_q <= resp_v0_d;
      resp_v1_q <= resp_v1_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  // Grant selection and lock tracking; a lock ends on an unlocked accept or a valid drop.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    state_d  = state_q;
    prio_d   = prio_q;
    case (state_q)
      ARB: begin
        grant0_c = req_valid_0 && (!req_valid_1 || !prio_q);
        grant1_c = req_valid_1 && (!req_valid_0 || prio_q);
        if (grant0_c && req_lock_0) begin
          state_d = LOCK0;
        end else if (grant1_c && req_lock_1) begin
          state_d = LOCK1;
        end
      end
      LOCK0: begin
        grant0_c = req_valid_0;
        if (!req_valid_0 || !req_lock_0) begin
          state_d = ARB;
        end
      end
      LOCK1: begin
        grant1_c = req_valid_1;
        if (!req_valid_1 || !req_lock_1) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (grant0_c) begin
      prio_d = 1'b1;
    end else if (grant1_c) begin
      prio_d = 1'b0;
    end
  end

  // Response tag and saturating accept counters.
  always_comb begin
    resp_v0_d = grant0_c;
    resp_v1_d = grant1_c;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (grant0_c && (cnt0_q != CNT_MAX)) begin
      cnt0_d = cnt0_q + CNT_WIDTH'(1);
    end
    if (grant1_c && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end
  end

  assign req_ready_0  = grant0_c;
  assign req_ready_1  = grant1_c;
  assign ram_addr     = grant1_c ? req_addr_1 : req_addr_0;
  assign ram_data     = grant1_c ? req_wdata_1 : req_wdata_0;
  assign ram_we       = (grant0_c && req_we_0) || (grant1_c && req_we_1);
  assign resp_valid_0 = resp_v0_q;
  assign resp_valid_1 = resp_v1_q;
  assign resp_data_0  = ram_out;
  assign resp_data_1  = ram_out;
  assign gnt_cnt_0    = cnt0_q;
  assign gnt_cnt_1    = cnt1_q;

endmodule
